// File: rtl/aha_clock_select_ctrl_pkg.sv
// Shared types for the clock-select controller: FSM states, select-bus width
// and the select-index type used on every select-carrying port.
package aha_clk_ctrl_pkg;

    localparam int SEL_W    = 3;
    localparam int MAX_CLKS = 1 << SEL_W;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DROP,
        ST_RAISE,
        ST_SETTLE
    } state_t;

    // A select index is usable only if a switch instance answers to it.
    function automatic logic sel_in_range(input sel_t sel, input int num_clks);
        return int'(sel) < num_clks;
    endfunction

endpackage

// File: rtl/aha_sync_ff.sv
// Multi-stage synchronizer for a vector of independent asynchronous level signals.
// Each bit is synchronized separately; there is no cross-bit coherency.
module aha_sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/aha_clock_select_ctrl.sv
// Sequencer for the glitch-free clock switch bank: drives the shared select bus,
// confirms release of the old source and engagement of the new one, then settles.
module aha_clock_select_ctrl
    import aha_clk_ctrl_pkg::*;
#(
    parameter int NUM_CLKS       = 6,
    parameter int RESET_SEL      = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SETTLE_CYCLES  = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                REQ_VALID,
    input  logic [SEL_W-1:0]    REQ_SEL,
    output logic                REQ_READY,
    input  logic [NUM_CLKS-1:0] SW_ACK,
    output logic [SEL_W-1:0]    SELECT_REQ,
    output logic [SEL_W-1:0]    CUR_SEL,
    output logic                DONE,
    output logic                ERR_TIMEOUT,
    output logic                ERR_RANGE,
    input  logic                ERR_CLR
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST    = SET_W'(SETTLE_CYCLES - 1);
    localparam sel_t             RESET_SEL_V = sel_t'(RESET_SEL);

    state_t           r_state;
    sel_t             r_sel_req;
    sel_t             r_cur_sel;
    sel_t             r_tgt;
    logic [TMR_W-1:0] r_timer;
    logic [SET_W-1:0] r_settle;
    logic             r_from_init;
    logic             r_done;
    logic             r_err_tmo;
    logic             r_err_rng;

    logic [NUM_CLKS-1:0] w_ack_s;
    logic [MAX_CLKS-1:0] w_ack_pad;
    logic [TMR_W-1:0]    w_timer_inc;
    logic                w_xfer;

    state_t           w_state_nxt;
    sel_t             w_sel_req_nxt;
    sel_t             w_cur_sel_nxt;
    sel_t             w_tgt_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [SET_W-1:0] w_settle_nxt;
    logic             w_from_init_nxt;
    logic             w_done_nxt;
    logic             w_set_tmo;
    logic             w_set_rng;

    aha_sync_ff #(
        .WIDTH  (NUM_CLKS),
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk   (CLK),
        .i_rst_n (RESETn),
        .i_d     (SW_ACK),
        .o_q     (w_ack_s)
    );

    // Widen to the full select space so any select value indexes safely.
    always_comb begin
        w_ack_pad                 = '0;
        w_ack_pad[NUM_CLKS-1:0]   = w_ack_s;
    end

    assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + TMR_W'(1);
    assign w_xfer      = REQ_VALID && (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_req_nxt   = r_sel_req;
        w_cur_sel_nxt   = r_cur_sel;
        w_tgt_nxt       = r_tgt;
        w_timer_nxt     = w_timer_inc;
        w_settle_nxt    = r_settle;
        w_from_init_nxt = r_from_init;
        w_done_nxt      = 1'b0;
        w_set_tmo       = 1'b0;
        w_set_rng       = 1'b0;

        unique case (r_state)
            ST_INIT: begin
                if (w_ack_pad[RESET_SEL_V] || (r_timer == TMR_LAST)) begin
                    w_set_tmo       = !w_ack_pad[RESET_SEL_V];
                    w_state_nxt     = ST_SETTLE;
                    w_settle_nxt    = '0;
                    w_from_init_nxt = 1'b1;
                end
            end

            ST_IDLE: begin
                if (w_xfer) begin
                    if (!sel_in_range(REQ_SEL, NUM_CLKS)) begin
                        w_set_rng  = 1'b1;
                        w_done_nxt = 1'b1;
                    end else if (REQ_SEL == r_cur_sel) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_sel_req_nxt = REQ_SEL;
                        w_tgt_nxt     = REQ_SEL;
                        w_timer_nxt   = '0;
                        w_state_nxt   = ST_DROP;
                    end
                end
            end

            ST_DROP: begin
                if (!w_ack_pad[r_cur_sel]) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_RAISE;
                end else if (r_timer == TMR_LAST) begin
                    w_set_tmo       = 1'b1;
                    w_sel_req_nxt   = r_cur_sel;
                    w_state_nxt     = ST_SETTLE;
                    w_settle_nxt    = '0;
                    w_from_init_nxt = 1'b0;
                end
            end

            ST_RAISE: begin
                // The new source is only trusted once its synced ack is seen high.
                if (w_ack_pad[r_tgt]) begin
                    w_cur_sel_nxt   = r_tgt;
                    w_state_nxt     = ST_SETTLE;
                    w_settle_nxt    = '0;
                    w_from_init_nxt = 1'b0;
                end else if (r_timer == TMR_LAST) begin
                    w_set_tmo       = 1'b1;
                    w_sel_req_nxt   = r_cur_sel;
                    w_state_nxt     = ST_SETTLE;
                    w_settle_nxt    = '0;
                    w_from_init_nxt = 1'b0;
                end
            end

            ST_SETTLE: begin
                if (r_settle == SET_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = !r_from_init;
                end else begin
                    w_settle_nxt = r_settle + SET_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state     <= ST_INIT;
            r_sel_req   <= RESET_SEL_V;
            r_cur_sel   <= RESET_SEL_V;
            r_tgt       <= RESET_SEL_V;
            r_timer     <= '0;
            r_settle    <= '0;
            r_from_init <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel_req   <= w_sel_req_nxt;
            r_cur_sel   <= w_cur_sel_nxt;
            r_tgt       <= w_tgt_nxt;
            r_timer     <= w_timer_nxt;
            r_settle    <= w_settle_nxt;
            r_from_init <= w_from_init_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Sticky errors: a new error event outranks a simultaneous clear.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_err_tmo <= 1'b0;
            r_err_rng <= 1'b0;
        end else begin
            r_err_tmo <= w_set_tmo ? 1'b1 : (ERR_CLR ? 1'b0 : r_err_tmo);
            r_err_rng <= w_set_rng ? 1'b1 : (ERR_CLR ? 1'b0 : r_err_rng);
        end
    end

    assign REQ_READY   = (r_state == ST_IDLE);
    assign SELECT_REQ  = r_sel_req;
    assign CUR_SEL     = r_cur_sel;
    assign DONE        = r_done;
    assign ERR_TIMEOUT = r_err_tmo;
    assign ERR_RANGE   = r_err_rng;

endmodule

// File: tb/tb_aha_clock_select_ctrl.sv
// Directed bench for the clock-select controller: bring-up, switch, no-op/range
// vector table, dead-target timeout, backpressure and mid-transfer reset.
module tb_aha_clock_select_ctrl;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic [2:0] REQ_SEL = 3'd0;
    logic       REQ_READY;
    logic [5:0] SW_ACK = 6'd0;
    logic [2:0] SELECT_REQ;
    logic [2:0] CUR_SEL;
    logic       DONE;
    logic       ERR_TIMEOUT;
    logic       ERR_RANGE;
    logic       ERR_CLR = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    aha_clock_select_ctrl #(
        .NUM_CLKS       (6),
        .RESET_SEL      (0),
        .TIMEOUT_CYCLES (1024),
        .SETTLE_CYCLES  (16),
        .SYNC_STAGES    (2)
    ) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .REQ_VALID   (REQ_VALID),
        .REQ_SEL     (REQ_SEL),
        .REQ_READY   (REQ_READY),
        .SW_ACK      (SW_ACK),
        .SELECT_REQ  (SELECT_REQ),
        .CUR_SEL     (CUR_SEL),
        .DONE        (DONE),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .ERR_RANGE   (ERR_RANGE),
        .ERR_CLR     (ERR_CLR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       v;
        logic [2:0] sel;
        logic       clr;
        logic       exp_done;
        logic       exp_rng;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Counts edges after reset release until REQ_READY; 2 sync + 1 INIT exit + 16 settle.
    task automatic bring_up(input string tag);
        int  cyc;
        bit  saw_done;
        cyc      = 0;
        saw_done = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            cyc++;
            if (DONE) saw_done = 1;
            if (REQ_READY) break;
        end
        check_range({tag, "_ready_latency"}, cyc, 18, 19);
        check({tag, "_no_done"}, 32'(saw_done), 0);
        check({tag, "_select_req"}, 32'(SELECT_REQ), 0);
        check({tag, "_cur_sel"}, 32'(CUR_SEL), 0);
    endtask

    initial begin
        int  c;
        int  done_cyc;
        int  tmo_cyc;
        bit  bad_ready;
        bit  bad_sel;

        vecs[0] = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0};  // no-op to current source
        vecs[1] = '{1'b1, 3'd7, 1'b0, 1'b1, 1'b1};  // out of range
        vecs[2] = '{1'b0, 3'd5, 1'b0, 1'b0, 1'b1};  // not valid: nothing happens
        vecs[3] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0};  // clear
        vecs[4] = '{1'b1, 3'd6, 1'b1, 1'b1, 1'b1};  // set beats simultaneous clear
        vecs[5] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0};  // clear
        vecs[6] = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b0};  // no-op with clear

        // Reset state
        SW_ACK = 6'b000001;
        #2 RESETn = 1'b0;
        #1;
        check("rst_select_req", 32'(SELECT_REQ), 0);
        check("rst_cur_sel", 32'(CUR_SEL), 0);
        check("rst_ready", 32'(REQ_READY), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_err_tmo", 32'(ERR_TIMEOUT), 0);
        check("rst_err_rng", 32'(ERR_RANGE), 0);
        repeat (3) @(posedge CLK);
        #1 RESETn = 1'b1;
        bring_up("bringup");

        // Switch 0 -> 3 with REQ_VALID held high throughout
        REQ_SEL   = 3'd3;
        REQ_VALID = 1'b1;
        step();
        c = 0;
        check("sw_select_req_next", 32'(SELECT_REQ), 3);
        check("sw_ready_low", 32'(REQ_READY), 0);
        bad_ready = 0;
        bad_sel   = 0;
        done_cyc  = -1;
        for (int i = 0; i < 200; i++) begin
            if (c == 5) SW_ACK[0] = 1'b0;
            if (c == 8) SW_ACK[3] = 1'b1;
            step();
            c++;
            if (DONE) begin
                done_cyc = c;
                break;
            end
            if (REQ_READY) bad_ready = 1;
            if (SELECT_REQ != 3'd3) bad_sel = 1;
        end
        REQ_VALID = 1'b0;
        check_range("sw_done_cycle", done_cyc, 26, 27);
        check("sw_cur_sel", 32'(CUR_SEL), 3);
        check("sw_ready_at_done", 32'(REQ_READY), 1);
        check("sw_ready_low_busy", 32'(bad_ready), 0);
        check("sw_bus_stable", 32'(bad_sel), 0);
        check("sw_err_tmo", 32'(ERR_TIMEOUT), 0);
        check("sw_err_rng", 32'(ERR_RANGE), 0);
        step();
        check("sw_done_single", 32'(DONE), 0);
        check("sw_single_capture", 32'(REQ_READY), 1);

        // IDLE vector table: no-op, range, valid-low, error clear
        for (int i = 0; i < 7; i++) begin
            REQ_VALID = vecs[i].v;
            REQ_SEL   = vecs[i].sel;
            ERR_CLR   = vecs[i].clr;
            step();
            REQ_VALID = 1'b0;
            ERR_CLR   = 1'b0;
            check($sformatf("vec%0d_done", i), 32'(DONE), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_err_rng", i), 32'(ERR_RANGE), 32'(vecs[i].exp_rng));
            check($sformatf("vec%0d_select_req", i), 32'(SELECT_REQ), 3);
            check($sformatf("vec%0d_ready", i), 32'(REQ_READY), 1);
        end
        check("vec_cur_sel", 32'(CUR_SEL), 3);

        // Dead target: source 5 never acknowledges
        REQ_SEL   = 3'd5;
        REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        SW_ACK[3] = 1'b0;
        c = 0;
        check("dead_select_req", 32'(SELECT_REQ), 5);
        done_cyc = -1;
        tmo_cyc  = -1;
        for (int i = 0; i < 1500; i++) begin
            step();
            c++;
            if (ERR_TIMEOUT && tmo_cyc < 0) begin
                tmo_cyc = c;
                check("dead_revert_sel", 32'(SELECT_REQ), 3);
                check("dead_ready_settle", 32'(REQ_READY), 0);
                SW_ACK[3] = 1'b1;
            end
            if (DONE) begin
                done_cyc = c;
                break;
            end
        end
        check_range("dead_tmo_cycle", tmo_cyc, 1026, 1027);
        check_range("dead_done_cycle", done_cyc, 1042, 1043);
        check("dead_err_tmo", 32'(ERR_TIMEOUT), 1);
        check("dead_cur_sel", 32'(CUR_SEL), 3);
        check("dead_select_final", 32'(SELECT_REQ), 3);
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        check("dead_err_clr", 32'(ERR_TIMEOUT), 0);

        // Reset asserted while waiting in RAISE for source 1
        REQ_SEL   = 3'd1;
        REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        SW_ACK[3] = 1'b0;
        repeat (6) step();
        check("mid_ready_raise", 32'(REQ_READY), 0);
        check("mid_select_pre", 32'(SELECT_REQ), 1);
        RESETn = 1'b0;
        #1;
        check("mid_rst_select_req", 32'(SELECT_REQ), 0);
        check("mid_rst_ready", 32'(REQ_READY), 0);
        check("mid_rst_cur_sel", 32'(CUR_SEL), 0);
        SW_ACK = 6'b000001;
        repeat (2) step();
        RESETn = 1'b1;
        bring_up("rebringup");
        check("rebringup_err_tmo", 32'(ERR_TIMEOUT), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
